// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-load and compute/drain sequencer
// for an N x N weight-stationary systolic MAC array.
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 load_weights,
    input  logic [CNT_W-1:0]     num_vectors,
    output logic                 w_rd,
    output logic [$clog2(N)-1:0] w_row_idx,
    output logic                 en_weight_pass,
    output logic [N-1:0]         en_weight_capture,
    input  logic                 act_valid,
    output logic                 act_pop,
    output logic                 act_lane_valid,
    output logic [N-1:0]         out_col_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int RW = $clog2(N);
    localparam int KW = $clog2(2 * N);
    localparam logic [KW-1:0] K_N    = KW'(N);
    localparam logic [KW-1:0] K_LAST = KW'(2 * N - 1);
    localparam logic [KW-1:0] D_LAST = KW'(2 * N - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        FIN
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_nx;
    logic [CNT_W-1:0] nv;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [2*N-2:0]   vsr;

    assign k_nx   = k + 1'b1;
    assign cnt_nx = cnt + 1'b1;

    // Pops follow the buffer directly so a bubble costs no extra cycle.
    assign act_pop        = (state == COMPUTE) && act_valid;
    assign act_lane_valid = act_pop;

    // Column c sees its psum N+c cycles after the vector entered.
    assign out_col_valid = vsr[2*N-2:N-1];

    // Sequencer state, counters and registered array controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            k                 <= '0;
            nv                <= '0;
            cnt               <= '0;
            w_rd              <= 1'b0;
            w_row_idx         <= '0;
            en_weight_pass    <= 1'b0;
            en_weight_capture <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        nv   <= num_vectors;
                        cnt  <= '0;
                        k    <= '0;
                        busy <= 1'b1;
                        if (load_weights) begin
                            state          <= LOAD;
                            en_weight_pass <= 1'b1;
                            w_rd           <= 1'b1;
                            w_row_idx      <= '0;
                        end else if (num_vectors == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= COMPUTE;
                        end
                    end
                end
                LOAD: begin
                    if (k == K_LAST) begin
                        k                 <= '0;
                        en_weight_pass    <= 1'b0;
                        en_weight_capture <= '0;
                        w_rd              <= 1'b0;
                        w_row_idx         <= '0;
                        if (nv == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= COMPUTE;
                        end
                    end else begin
                        k    <= k_nx;
                        w_rd <= (k_nx < K_N);
                        if (k_nx < K_N)
                            w_row_idx <= k_nx[RW-1:0];
                        else
                            w_row_idx <= '0;
                        // Row r latches when its weights reach it at k=2r+1.
                        if (k_nx[0])
                            en_weight_capture <= N'(1) << k_nx[KW-1:1];
                        else
                            en_weight_capture <= '0;
                    end
                end
                COMPUTE: begin
                    if (act_valid) begin
                        cnt <= cnt_nx;
                        if (cnt_nx == nv) begin
                            state <= DRAIN;
                            k     <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (k == D_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        k <= k_nx;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Track which wavefronts carry real data down the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vsr <= '0;
        else
            vsr <= {vsr[2*N-3:0], act_lane_valid};
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized checks of systolic_ctrl against
// a cycle-level phase model of the sequencing rules.
module tb_systolic_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             load_weights;
    logic [CNT_W-1:0] num_vectors;
    logic             w_rd;
    logic [1:0]       w_row_idx;
    logic             en_weight_pass;
    logic [N-1:0]     en_weight_capture;
    logic             act_valid;
    logic             act_pop;
    logic             act_lane_valid;
    logic [N-1:0]     out_col_valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [15:0] obs;
    assign obs = {busy, done, w_rd, w_row_idx, en_weight_pass,
                  en_weight_capture, act_pop, act_lane_valid,
                  out_col_valid};

    systolic_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .load_weights      (load_weights),
        .num_vectors       (num_vectors),
        .w_rd              (w_rd),
        .w_row_idx         (w_row_idx),
        .en_weight_pass    (en_weight_pass),
        .en_weight_capture (en_weight_capture),
        .act_valid         (act_valid),
        .act_pop           (act_pop),
        .act_lane_valid    (act_lane_valid),
        .out_col_valid     (out_col_valid),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // Phase codes of the model: 0 load, 1 compute, 2 drain, 3 fin, 4 idle.
    task automatic run_scenario(input string name, input bit lw,
                                input int nv, input int mode,
                                input bit noise);
        bit   hist[256];
        int   issued = 0;
        int   last_pop = -1;
        int   fin_t;
        int   ci = 0;
        int   idle = 0;
        int   pops = 0;
        int   dones = 0;
        int   ph;
        bit   finished = 0;
        logic e_pop;
        logic [1:0]  e_idx;
        logic [3:0]  e_cap;
        logic [3:0]  e_ocv;
        logic [15:0] exp_v;
        fin_t = (nv == 0) ? (lw ? 2 * N : 0) : 1000;
        @(negedge clk);
        start        = 1'b1;
        load_weights = lw;
        num_vectors  = CNT_W'(nv);
        act_valid    = 1'(($urandom));
        for (int t = 0; t < 200; t++) begin
            if (lw && t < 2 * N)                      ph = 0;
            else if (nv > 0 && issued < nv)           ph = 1;
            else if (nv > 0 && t < last_pop + 2 * N)  ph = 2;
            else if (t == fin_t)                      ph = 3;
            else                                      ph = 4;
            @(negedge clk);
            start = noise && ph != 4 && $urandom_range(0, 2) == 0;
            load_weights = 1'($urandom);
            num_vectors  = CNT_W'($urandom);
            if (ph == 1 && mode == 0)
                act_valid = 1'b1;
            else if (ph == 1 && mode == 1)
                act_valid = (ci % 4 == 0) || (ci % 4 == 3);
            else
                act_valid = 1'($urandom);
            if (ph == 1) ci++;
            #1;
            e_pop = (ph == 1) && act_valid;
            hist[t] = e_pop;
            if (e_pop) begin
                issued++;
                if (issued == nv) begin
                    last_pop = t;
                    fin_t    = t + 2 * N;
                end
            end
            e_idx = (ph == 0 && t < N) ? 2'(t) : 2'd0;
            e_cap = (ph == 0 && t % 2 == 1) ? 4'(1 << (t / 2)) : 4'd0;
            for (int c = 0; c < N; c++)
                e_ocv[c] = (t >= N + c) ? hist[t-N-c] : 1'b0;
            exp_v = {ph != 4, ph == 3, ph == 0 && t < N, e_idx,
                     ph == 0, e_cap, e_pop, e_pop, e_ocv};
            if (act_pop) pops++;
            if (done) dones++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s cycle=%0d outputs got=%h exp=%h",
                         name, t, obs, exp_v);
            end
            if (ph == 4) idle++;
            if (idle >= 2) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout got=running exp=idle", name);
        end
        checks++;
        if (pops != nv || dones != 1) begin
            errors++;
            $display("FAIL %s totals got pops=%0d dones=%0d exp pops=%0d dones=1",
                     name, pops, dones, nv);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        load_weights = 1'b0;
        num_vectors = '0;
        act_valid = 1'b1;
        #3;
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL reset_async got=%h exp=0000", obs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=0000", obs);
        end
    endtask

    task automatic test_abort();
        bit saw_done = 0;
        @(negedge clk);
        start = 1'b1;
        load_weights = 1'b0;
        num_vectors = 4'd12;
        act_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL abort_async got=%h exp=0000", obs);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done || obs !== 16'h0) begin
            errors++;
            $display("FAIL abort_idle got=%h done_seen=%0d exp=0000 done_seen=0",
                     obs, saw_done);
        end
    endtask

    initial begin
        test_reset();
        run_scenario("load_only", 1, 0, 0, 0);
        run_scenario("load_compute", 1, 3, 0, 0);
        run_scenario("pattern_1001", 0, 2, 1, 0);
        run_scenario("zero_no_load", 0, 0, 2, 0);
        run_scenario("start_ignored_a", 1, 5, 2, 1);
        run_scenario("start_ignored_b", 0, 6, 2, 1);
        test_abort();
        run_scenario("after_abort", 1, 3, 2, 0);
        run_scenario("max_count", 1, 15, 0, 0);
        run_scenario("max_count_rand", 0, 15, 2, 1);
        for (int i = 0; i < 6; i++)
            run_scenario("random", 1'($urandom), $urandom_range(0, 15),
                         2, 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
